// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for segmented pipelined arithmetic: stage count and
// WIDTH/SEG legality check (also used by the pipelined accumulator).
package pipelined_rca_pkg;

  function automatic bit seg_split_ok(int width, int seg);
    if (seg < 1) return 1'b0;
    if (width < seg) return 1'b0;
    return (width % seg) == 0;
  endfunction

  function automatic int calc_stages(int width, int seg);
    if (seg < 1) return 1;
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry slice; exposes the carry into its top
// bit so the last slice can form the signed-overflow flag.
module rca_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           ci,
  output logic [SEG-1:0] s_seg,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] c;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    c     = '0;
    s_seg = '0;
    c[0]  = ci;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// registered inter-stage carry, skewed operands and de-skewed sum.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);
  localparam logic [WIDTH-1:0] SEG_ONES = {WIDTH{1'b1}} >> (WIDTH - SEG);

  if (!seg_split_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a non-zero multiple of SEG (SEG >= 1)");
  end

  // Registered state of each stage: operands still to be consumed by higher
  // stages, sum segments already resolved, carry out and valid bit.
  logic [STAGES-1:0]            v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic                         ovf_q;

  // Inputs presented to each stage and its next-state sum.
  logic [STAGES-1:0]            in_v, in_c, seg_co, seg_cmsb;
  logic [STAGES-1:0][WIDTH-1:0] in_a, in_b, in_s, nxt_s;

  logic stall;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] s_seg;

    if (k == 0) begin : g_head
      // Subtraction folds into the first stage: A + ~B + (cin ^ 1).
      assign in_a[k] = a;
      assign in_b[k] = sub ? ~b : b;
      assign in_c[k] = cin ^ sub;
      assign in_v[k] = in_valid;
      assign in_s[k] = '0;
    end else begin : g_body
      assign in_a[k] = a_q[k-1];
      assign in_b[k] = b_q[k-1];
      assign in_c[k] = c_q[k-1];
      assign in_v[k] = v_q[k-1];
      assign in_s[k] = s_q[k-1];
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a_seg (in_a[k][k*SEG +: SEG]),
      .b_seg (in_b[k][k*SEG +: SEG]),
      .ci    (in_c[k]),
      .s_seg (s_seg),
      .co    (seg_co[k]),
      .c_msb (seg_cmsb[k])
    );

    assign nxt_s[k] = (in_s[k] & ~(SEG_ONES << (k*SEG))) | (WIDTH'(s_seg) << (k*SEG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too so sum/cout/ovf are never X after reset.
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking updates make every stage sample its predecessor's old value.
      v_q   <= in_v;
      c_q   <= seg_co;
      a_q   <= in_a;
      b_q   <= in_b;
      s_q   <= nxt_s;
      ovf_q <= seg_cmsb[STAGES-1] ^ seg_co[STAGES-1];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
